// File: rtl/note_window_scheduler.sv
// Rhythm-game note scheduler: fetches chart entries, parks them in one slot
// per lane, and reports per-lane perfect/okay hit windows and missed notes.
//
// Handshake: chart_req is held high in FETCH; the chart source answers with
// chart_ack for one cycle with chart_tick/chart_lanes/chart_end valid in that
// same cycle. There is no back-pressure: the entry is latched on that edge.
module note_window_scheduler #(
  parameter int TS_W      = 16,
  parameter int ADDR_W    = 10,
  parameter int PERF_WIN  = 2,
  parameter int OKAY_WIN  = 5,
  parameter int LOOKAHEAD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              tick_en,
  output logic              chart_req,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic              chart_ack,
  input  logic [TS_W-1:0]   chart_tick,
  input  logic [3:0]        chart_lanes,
  input  logic              chart_end,
  input  logic [3:0]        hit_perfect,
  input  logic [3:0]        hit_okay,
  output logic [3:0]        lane_active_perfect,
  output logic [3:0]        lane_active_okay,
  output logic [3:0]        note_expired,
  output logic [TS_W-1:0]   song_time,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [TS_W:0] PERF_X = (TS_W+1)'(PERF_WIN);
  localparam logic [TS_W:0] OKAY_X = (TS_W+1)'(OKAY_WIN);
  localparam logic [TS_W:0] LOOK_X = (TS_W+1)'(LOOKAHEAD);

  state_t            state, state_nx;
  logic [3:0]        valid;
  logic [TS_W-1:0]   slot_t [4];
  logic [TS_W-1:0]   ent_tick;
  logic [3:0]        ent_lanes;
  logic [3:0]        past;
  logic              restart, addr_inc, latch, load, fits;

  assign dbg_state    = state;
  assign chart_req    = (state == S_FETCH);
  assign busy         = (state == S_FETCH) || (state == S_HOLD) || (state == S_DRAIN);
  assign done         = (state == S_DONE);
  assign note_expired = past;
  assign fits         = ({1'b0, ent_tick} <= ({1'b0, song_time} + LOOK_X));

  // Per-lane window classification from the registered slots and song time.
  always_comb begin
    lane_active_okay    = '0;
    lane_active_perfect = '0;
    past                = '0;
    for (int i = 0; i < 4; i++) begin
      logic signed [TS_W:0] d;
      logic [TS_W:0]        mag;
      d   = $signed({1'b0, song_time}) - $signed({1'b0, slot_t[i]});
      mag = d[TS_W] ? 
            (TS_W+1)'(-d) : (TS_W+1)'(d);
      lane_active_okay[i]    = valid[i] && (mag <= OKAY_X);
      lane_active_perfect[i] = valid[i] && (mag <= PERF_X);
      past[i] = valid[i] && ({1'b0, song_time} > ({1'b0, slot_t[i]} + OKAY_X));
    end
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    addr_inc = 1'b0;
    latch    = 1'b0;
    load     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          restart  = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (chart_ack) begin
          latch = 1'b1;
          if (chart_end)              state_nx = S_DRAIN;
          else if (chart_lanes == '0) addr_inc = 1'b1;
          else                        state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (((valid & ent_lanes) == '0) && fits) begin
          load     = 1'b1;
          addr_inc = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (valid == '0) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, chart address, song clock and latched entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      chart_addr <= '0;
      song_time  <= '0;
      ent_tick   <= '0;
      ent_lanes  <= '0;
    end else begin
      state <= state_nx;
      if (restart) begin
        chart_addr <= '0;
        song_time  <= '0;
      end else begin
        if (addr_inc) chart_addr <= chart_addr + 1'b1;
        if (busy && tick_en && (song_time != '1)) song_time <= song_time + 1'b1;
      end
      if (latch) begin
        ent_tick  <= chart_tick;
        ent_lanes <= chart_lanes;
      end
    end
  end

  // Lane slots: load from the held entry, clear on hit or miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < 4; i++) slot_t[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load && ent_lanes[i]) begin
          valid[i]  <= 1'b1;
          slot_t[i] <= ent_tick;
        end else if (((hit_perfect[i] || hit_okay[i]) && lane_active_okay[i]) || past[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_window_scheduler.sv
// Directed bench for note_window_scheduler with hand-computed expectations.
module tb_note_window_scheduler;

  logic        clk = 1'b0;
  logic        reset, start, tick_en, chart_req, chart_ack, chart_end, busy, done;
  logic [9:0]  chart_addr;
  logic [15:0] chart_tick, song_time;
  logic [3:0]  chart_lanes, hit_perfect, hit_okay;
  logic [3:0]  lane_active_perfect, lane_active_okay, note_expired;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  note_window_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .tick_en(tick_en),
    .chart_req(chart_req), .chart_addr(chart_addr), .chart_ack(chart_ack),
    .chart_tick(chart_tick), .chart_lanes(chart_lanes), .chart_end(chart_end),
    .hit_perfect(hit_perfect), .hit_okay(hit_okay),
    .lane_active_perfect(lane_active_perfect), .lane_active_okay(lane_active_okay),
    .note_expired(note_expired), .song_time(song_time), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    tick_en = 1'b1;
    step();
    tick_en = 1'b0;
  endtask

  task automatic ack(input logic [15:0] t, input logic [3:0] l, input logic e);
    chart_ack = 1'b1; chart_tick = t; chart_lanes = l; chart_end = e;
    step();
    chart_ack = 1'b0; chart_tick = '0; chart_lanes = '0; chart_end = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] win(input int st, input int t, input int w, input logic [3:0] m);
    return ((st >= t - w) && (st <= t + w)) ? m : 4'b0000;
  endfunction

  initial begin
    reset = 1'b1; start = 0; tick_en = 0; chart_ack = 0; chart_tick = '0;
    chart_lanes = '0; chart_end = 0; hit_perfect = '0; hit_okay = '0;
    step(); step();
    chk("rst_state", dbg_state, 0);
    chk("rst_req", chart_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_time", song_time, 0);
    chk("rst_addr", chart_addr, 0);
    chk("rst_exp", note_expired, 0);
    reset = 1'b0;

    // Start, then reset while requesting
    start = 1; step(); start = 0;
    chk("start_req", chart_req, 1);
    chk("start_busy", busy, 1);
    reset = 1; step(); reset = 0;
    chk("midrst_req", chart_req, 0);
    chk("midrst_state", dbg_state, 0);
    chk("midrst_busy", busy, 0);

    // Note T=20 on lane 0, perfect hit at 19
    start = 1; step(); start = 0;
    ack(16'd20, 4'b0001, 1'b0);
    chk("hold1_state", dbg_state, 2);
    chk("hold1_req", chart_req, 0);
    for (int st = 1; st <= 19; st++) begin
      adv();
      chk("t20_time", song_time, st);
      chk("t20_okay", lane_active_okay, win(st, 20, 5, 4'b0001));
      chk("t20_perf", lane_active_perfect, win(st, 20, 2, 4'b0001));
    end
    chk("t20_addr", chart_addr, 1);
    hit_perfect = 4'b0001; step(); hit_perfect = '0;
    chk("hit_okay_clr", lane_active_okay, 0);
    chk("hit_noexp", note_expired, 0);
    for (int st = 20; st <= 27; st++) begin
      adv();
      chk("post_hit_exp", note_expired, 0);
      chk("post_hit_okay", lane_active_okay, 0);
    end

    // Note T=40 on lane 0, no hit: expires at 46
    ack(16'd40, 4'b0001, 1'b0);
    step();
    chk("t40_addr", chart_addr, 2);
    for (int st = 28; st <= 47; st++) begin
      adv();
      chk("t40_okay", lane_active_okay, (st <= 45) ? win(st, 40, 5, 4'b0001) : 4'b0000);
      chk("t40_perf", lane_active_perfect, win(st, 40, 2, 4'b0001));
      chk("t40_exp", note_expired, (st == 46) ? 4'b0001 : 4'b0000);
    end

    // Lane conflict: T=60 on lane 0, then T=64 on lanes 0 and 2 waits
    ack(16'd60, 4'b0001, 1'b0);
    step();
    chk("t60_addr", chart_addr, 3);
    ack(16'd64, 4'b0101, 1'b0);
    step();
    chk("conf_state", dbg_state, 2);
    chk("conf_req", chart_req, 0);
    for (int st = 48; st <= 56; st++) begin
      adv();
      chk("conf_hold", dbg_state, 2);
      chk("conf_req_lo", chart_req, 0);
      chk("conf_okay", lane_active_okay, win(st, 60, 5, 4'b0001));
    end
    hit_okay = 4'b0001; step(); hit_okay = '0;
    chk("conf_hit_state", dbg_state, 2);
    chk("conf_hit_okay", lane_active_okay, 0);
    chk("conf_hit_exp", note_expired, 0);
    step();
    chk("conf_load_state", dbg_state, 1);
    chk("conf_load_req", chart_req, 1);
    chk("conf_load_addr", chart_addr, 4);
    for (int st = 57; st <= 70; st++) begin
      adv();
      chk("t64_okay", lane_active_okay, (st <= 69) ? win(st, 64, 5, 4'b0101) : 4'b0000);
      chk("t64_exp", note_expired, (st == 70) ? 4'b0101 : 4'b0000);
    end

    // Note already past its window expires one cycle after load
    ack(16'd10, 4'b1000, 1'b0);
    chk("late_hold_exp", note_expired, 0);
    step();
    chk("late_addr", chart_addr, 5);
    chk("late_exp", note_expired, 4'b1000);
    step();
    chk("late_exp_gone", note_expired, 0);

    // Empty lane mask is skipped
    ack(16'd99, 4'b0000, 1'b0);
    chk("skip_state", dbg_state, 1);
    chk("skip_addr", chart_addr, 6);

    // Far-ahead note T=100 waits until song_time 84
    ack(16'd100, 4'b0001, 1'b0);
    for (int st = 71; st <= 84; st++) begin
      adv();
      chk("far_hold", dbg_state, 2);
      chk("far_addr", chart_addr, 6);
    end
    step();
    chk("far_load_state", dbg_state, 1);
    chk("far_load_addr", chart_addr, 7);
    chk("far_time", song_time, 84);

    // End marker, drain, finish, restart
    ack(16'd0, 4'b0000, 1'b1);
    chk("drain_state", dbg_state, 3);
    chk("drain_req", chart_req, 0);
    chk("drain_busy", busy, 1);
    start = 1; step(); start = 0;
    chk("busy_start_state", dbg_state, 3);
    chk("busy_start_addr", chart_addr, 7);
    chk("busy_start_time", song_time, 84);
    for (int st = 85; st <= 98; st++) begin
      adv();
      chk("t100_okay", lane_active_okay, win(st, 100, 5, 4'b0001));
      chk("t100_perf", lane_active_perfect, win(st, 100, 2, 4'b0001));
    end
    hit_okay = 4'b0001; step(); hit_okay = '0;
    chk("drain_hit_state", dbg_state, 3);
    chk("drain_hit_done", done, 0);
    chk("drain_hit_exp", note_expired, 0);
    step();
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    step();
    chk("done_held", done, 1);
    start = 1; step(); start = 0;
    chk("restart_addr", chart_addr, 0);
    chk("restart_time", song_time, 0);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/note_window_scheduler.md
NOTE_WINDOW_SCHEDULER -- requirements
Module: note_window_scheduler

Interface
REQ-001 SHALL have parameters (one per line: name, default, meaning):
- TS_W, 16, song-time and note-time width
- ADDR_W, 10, chart address width
- PERF_WIN, 2, perfect half-window in ticks
- OKAY_WIN, 5, okay half-window in ticks; PERF_WIN <= OKAY_WIN
- LOOKAHEAD, 16, max ticks ahead of song_time a note may be loaded
REQ-002 SHALL have ports (one per line: name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse; begin song from chart address 0
- tick_en  in  1  one-cycle game-tick strobe
- chart_req  out  1  chart fetch request
- chart_addr  out  ADDR_W  chart entry address
- chart_ack  in  1  entry valid this cycle
- chart_tick  in  TS_W  entry target time T
- chart_lanes  in  4  entry lane mask
- chart_end  in  1  entry is end marker
- hit_perfect  in  4  per-lane perfect hit pulse
- hit_okay  in  4  per-lane okay hit pulse
- lane_active_perfect  out  4  lane inside perfect window
- lane_active_okay  out  4  lane inside okay window
- note_expired  out  4  one-cycle pulse, note missed
- song_time  out  TS_W  current song tick count
- busy  out  1  song in progress
- done  out  1  song finished, held

Function
REQ-003 SHALL keep one note slot per lane: valid bit plus target T (TS_W bits).
REQ-004 SHALL implement FSM states IDLE, FETCH, HOLD, DRAIN, DONE.
REQ-005 IDLE/DONE: start -> clear chart_addr and song_time to 0, go FETCH; busy = 1 in FETCH/HOLD/DRAIN only.
REQ-006 FETCH: chart_req = 1 until chart_ack; on ack, latch entry; chart_end -> DRAIN; chart_lanes == 0 -> discard, chart_addr+1, stay FETCH; else -> HOLD.
REQ-007 HOLD: load entry when every targeted lane slot is invalid (registered value) and T <= song_time + LOOKAHEAD (TS_W+1-bit compare); on load set valid and T in targeted slots, chart_addr+1, go FETCH; else wait.
REQ-008 DRAIN: no fetches; go DONE in the cycle after all slots are invalid; done = 1 in DONE until start or reset.
REQ-009 song_time SHALL increment by 1 on tick_en in FETCH, HOLD, DRAIN; saturate at all-ones; hold otherwise.
REQ-010 lane_active_okay[i] SHALL be combinational: valid[i] and |song_time - T[i]| <= OKAY_WIN, difference computed signed in TS_W+1 bits.
REQ-011 lane_active_perfect[i] likewise with PERF_WIN; perfect implies okay.
REQ-012 Hit: (hit_perfect[i] or hit_okay[i]) while lane_active_okay[i] SHALL clear valid[i] at next edge; hits on inactive lanes ignored.
REQ-013 Expiry: valid[i] and song_time > T[i] + OKAY_WIN (TS_W+1 bits) SHALL clear valid[i] and pulse note_expired[i] for exactly one cycle.
REQ-014 Hit and expiry are mutually exclusive per lane; a slot freed at an edge SHALL be reloadable no earlier than the following cycle.
REQ-015 A note loaded with T already past its window SHALL expire one cycle after load.
REQ-016 start while busy SHALL be ignored.

Reset
REQ-017 reset SHALL force IDLE, all slots invalid, chart_addr = 0, song_time = 0, chart_req = 0, note_expired = 0, busy = 0, done = 0; mid-song reset drops pending entry with no expiry pulses.

Verification
REQ-018 Reset during FETCH with chart_req = 1 -> next cycle all outputs 0, state IDLE.
REQ-019 Entry T=20, lanes 0001: okay[0]=1 at song_time 15..25, perfect[0]=1 at 18..22; hit_perfect[0] at 19 -> slot cleared, no note_expired.
REQ-020 Same entry, no hit -> song_time 26 -> note_expired = 0001 for one cycle, okay[0] = 0.
REQ-021 Lane 0 busy (T=20), next entry T=24 lanes 0101 -> HOLD, chart_req = 0 until lane 0 cleared, then both lanes 0 and 2 load T=24.
REQ-022 Entry T=100 at song_time 10 -> held in HOLD until song_time = 84, loaded that cycle.
REQ-023 chart_end at address 3 with one note pending -> DRAIN; after expiry/hit, done = 1, busy = 0; start -> chart_addr = 0, song_time = 0.
